// File: rtl/ui_conditioner.sv
// Input conditioner: per-channel 2-flop synchroniser, debounce counter, stable level and registered press/release pulses.
// Optional auto-repeat on held presses is enabled with the UI_COND_REPEAT_EN macro. The release pulse port is release_pulse because release is a reserved word.
module ui_conditioner #(
    parameter int WIDTH         = 8,
    parameter int DEBOUNCE      = 16,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse
);

    localparam int CW = $clog2(DEBOUNCE);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    if (DEBOUNCE < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_illegal_cfg
        $error("ui_conditioner: DEBOUNCE, REPEAT_DELAY and REPEAT_PERIOD must all be >= 2");
    end

    logic [WIDTH-1:0]         s1_r;
    logic [WIDTH-1:0]         s2_r;
    logic [WIDTH-1:0][CW-1:0] cnt_r;
    logic [WIDTH-1:0][CW-1:0] cnt_s;
    logic [WIDTH-1:0]         level_r;
    logic [WIDTH-1:0]         level_s;
    logic [WIDTH-1:0]         press_r;
    logic [WIDTH-1:0]         release_r;
    logic [WIDTH-1:0]         rise_s;
    logic [WIDTH-1:0]         fall_s;
    logic [WIDTH-1:0]         press_s;

    // Debounce next-state: a mismatch must persist for DEBOUNCE samples before the level flips.
    always_comb begin
        cnt_s   = cnt_r;
        level_s = level_r;
        rise_s  = '0;
        fall_s  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2_r[i] == level_r[i]) begin
                cnt_s[i] = '0;
            end else if (cnt_r[i] == CNT_MAX) begin
                level_s[i] = s2_r[i];
                cnt_s[i]   = '0;
                rise_s[i]  = s2_r[i];
                fall_s[i]  = ~s2_r[i];
            end else begin
                cnt_s[i] = cnt_r[i] + CW'(1);
            end
        end
    end

`ifdef UI_COND_REPEAT_EN
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX);
    localparam logic [HW-1:0] DLY_MAX = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PER_MAX = HW'(REPEAT_PERIOD - 1);

    logic [WIDTH-1:0][HW-1:0] hcnt_r;
    logic [WIDTH-1:0][HW-1:0] hcnt_s;
    logic [WIDTH-1:0]         phase_r;
    logic [WIDTH-1:0]         phase_s;
    logic [WIDTH-1:0]         rpt_s;

    // Hold counter: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD; the release edge wins over a repeat.
    always_comb begin
        hcnt_s  = hcnt_r;
        phase_s = phase_r;
        rpt_s   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!level_r[i] || fall_s[i]) begin
                hcnt_s[i]  = '0;
                phase_s[i] = 1'b0;
            end else if (hcnt_r[i] == (phase_r[i] ? PER_MAX : DLY_MAX)) begin
                rpt_s[i]   = 1'b1;
                hcnt_s[i]  = '0;
                phase_s[i] = 1'b1;
            end else begin
                hcnt_s[i] = hcnt_r[i] + HW'(1);
            end
        end
    end

    // Hold counter and delay/period phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_r  <= '0;
            phase_r <= '0;
        end else begin
            hcnt_r  <= hcnt_s;
            phase_r <= phase_s;
        end
    end

    assign press_s = rise_s | rpt_s;
`else
    assign press_s = rise_s;
`endif

    // Synchroniser, debounce state and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r      <= '0;
            s2_r      <= '0;
            cnt_r     <= '0;
            level_r   <= '0;
            press_r   <= '0;
            release_r <= '0;
        end else begin
            s1_r      <= raw_in;
            s2_r      <= s1_r;
            cnt_r     <= cnt_s;
            level_r   <= level_s;
            press_r   <= press_s;
            release_r <= fall_s;
        end
    end

    assign level         = level_r;
    assign press         = press_r;
    assign release_pulse = release_r;

endmodule

// File: tb/tb_ui_conditioner.sv
// Directed bench for ui_conditioner with DEBOUNCE=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
module tb_ui_conditioner;

    logic       clk;
    logic       rst;
    logic [7:0] raw_in;
    logic [7:0] level;
    logic [7:0] press;
    logic [7:0] release_pulse;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef UI_COND_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    ui_conditioner #(
        .WIDTH(8), .DEBOUNCE(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk), .rst(rst), .raw_in(raw_in),
        .level(level), .press(press), .release_pulse(release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] raw;
        logic [7:0] lvl;
        logic [7:0] prs;
        logic [7:0] rls;
        int         reps;
    } vec_t;

    vec_t tv [19];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    initial begin
        int j;
        int np;
        int nr;
        logic [7:0] e;

        // raw is applied before edge j; expectations hold after edge j
        tv = '{
            '{8'h01, 8'h00, 8'h00, 8'h00, 5},
            '{8'h01, 8'h01, 8'h01, 8'h00, 1},
            '{8'h01, 8'h01, 8'h00, 8'h00, 1},
            '{8'h00, 8'h01, 8'h00, 8'h00, 5},
            '{8'h00, 8'h00, 8'h00, 8'h01, 1},
            '{8'h00, 8'h00, 8'h00, 8'h00, 1},
            '{8'h08, 8'h00, 8'h00, 8'h00, 3},
            '{8'h00, 8'h00, 8'h00, 8'h00, 6},
            '{8'h08, 8'h00, 8'h00, 8'h00, 5},
            '{8'h08, 8'h08, 8'h08, 8'h00, 1},
            '{8'h08, 8'h08, 8'h00, 8'h00, 1},
            '{8'h00, 8'h08, 8'h00, 8'h00, 5},
            '{8'h00, 8'h00, 8'h00, 8'h08, 1},
            '{8'h42, 8'h00, 8'h00, 8'h00, 5},
            '{8'h42, 8'h42, 8'h42, 8'h00, 1},
            '{8'h42, 8'h42, 8'h00, 8'h00, 1},
            '{8'h00, 8'h42, 8'h00, 8'h00, 5},
            '{8'h00, 8'h00, 8'h00, 8'h42, 1},
            '{8'h00, 8'h00, 8'h00, 8'h00, 2}
        };

        rst    = 1'b1;
        raw_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset level", level, 8'h00);
        chk("reset press", press, 8'h00);
        chk("reset release", release_pulse, 8'h00);
        rst = 1'b0;

        // Table: clean press/release, glitch rejection, simultaneous channels
        j = 0;
        for (int r = 0; r < 19; r++) begin
            for (int k = 0; k < tv[r].reps; k++) begin
                raw_in = tv[r].raw;
                @(negedge clk);
                chk($sformatf("vec%0d level", j), level, tv[r].lvl);
                chk($sformatf("vec%0d press", j), press, tv[r].prs);
                chk($sformatf("vec%0d release", j), release_pulse, tv[r].rls);
                j++;
            end
        end

        // Chatter on bit5 every 2 cycles, then settle high
        np = 0;
        nr = 0;
        for (int c = 0; c < 48; c++) begin
            raw_in = (c < 40 && ((c / 2) % 2) == 1) ? 8'h00 : 8'h20;
            @(negedge clk);
            if (press[5]) np++;
            if (release_pulse[5]) nr++;
        end
        chk("chatter press count", 8'(np), 8'd1);
        chk("chatter release count", 8'(nr), 8'd0);
        chk("chatter final level", level, 8'h20);
        raw_in = 8'h00;
        repeat (8) @(negedge clk);
        chk("chatter cleared", level, 8'h00);

        // Reset two cycles into the bit2 count
        raw_in = 8'h04;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst level", level, 8'h00);
        chk("midrst press", press, 8'h00);
        rst = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            e = (n == 6) ? 8'h04 : 8'h00;
            chk($sformatf("postrst%0d press", n), press, e);
            chk($sformatf("postrst%0d level", n), level, e);
        end
        raw_in = 8'h00;
        repeat (8) @(negedge clk);
        chk("postrst cleared", level, 8'h00);

        // Held press on bit0: auto-repeat when enabled, single press otherwise
        for (int c = 0; c < 37; c++) begin
            raw_in = (c < 28) ? 8'h01 : 8'h00;
            @(negedge clk);
            e = (c == 5 || (REP && (c == 15 || c == 20 || c == 25 || c == 30))) ? 8'h01 : 8'h00;
            chk($sformatf("hold%0d press", c), press, e);
            e = (c == 33) ? 8'h01 : 8'h00;
            chk($sformatf("hold%0d release", c), release_pulse, e);
        end
        chk("hold final level", level, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
